// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiplier: o_out = a * b * 2^(-MOD_WIDTH) mod N.
// One bit of a is consumed per clock, LSB first, followed by one final reduction cycle.
module montgomery_mul #(
  parameter int MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_a,
  input  logic [MOD_WIDTH-1:0] i_b,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out
);

  localparam int CW = $clog2(MOD_WIDTH) + 1;
  localparam int IW = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOOP, FINAL, OUT} state_t;

  state_t               state;
  logic [MOD_WIDTH-1:0] a;
  logic [MOD_WIDTH-1:0] b;
  logic [MOD_WIDTH-1:0] n;
  logic [MOD_WIDTH:0]   r;
  logic [CW-1:0]        count;

  logic                 a_bit;
  logic [MOD_WIDTH+1:0] s_add;
  logic [MOD_WIDTH:0]   r_next;
  logic [MOD_WIDTH:0]   r_sub;
  logic                 r_ge_n;

  assign i_ready = (state == IDLE);
  assign a_bit   = a[count[IW-1:0]];

  // s_add is odd only when N gets added, and odd + odd N halves to
  // (s_add >> 1) + (N >> 1) + 1, so the full s never has to be built.
  always_comb begin
    s_add  = {1'b0, r} + (a_bit ? {2'b00, b} : '0);
    r_next = s_add[MOD_WIDTH+1:1] + (s_add[0] ? (({1'b0, n} >> 1) + 1'b1) : '0);
    r_ge_n = (r >= {1'b0, n});
    r_sub  = r - {1'b0, n};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      n       <= '0;
      r       <= '0;
      count   <= '0;
      o_valid <= 1'b0;
      o_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a     <= i_a;
            b     <= i_b;
            n     <= i_modulus;
            r     <= '0;
            count <= '0;
            state <= LOOP;
          end
        end
        LOOP: begin
          r     <= r_next;
          count <= count + CW'(1);
          if (count == LAST) state <= FINAL;
        end
        FINAL: begin
          if (r_ge_n) r <= r_sub;
          o_out   <= r_ge_n ? r_sub[MOD_WIDTH-1:0] : r[MOD_WIDTH-1:0];
          o_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul.sv
// Directed bench for montgomery_mul at MOD_WIDTH = 8 (R = 256).
// Expected values are hand-derived or come from a brute-force modular reference.
module tb_montgomery_mul;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [W-1:0] i_modulus = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_out;

  int checks = 0;
  int errors = 0;

  montgomery_mul #(.MOD_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_modulus (i_modulus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out)
  );

  always #5 clk = ~clk;

  // Finds r in [0, n) with r * 256 == a * b (mod n).
  function automatic int mont_ref(input int a, input int b, input int n);
    int ab;
    ab = (a * b) % n;
    for (int r = 0; r < n; r++)
      if ((r * 256) % n == ab) return r;
    return -1;
  endfunction

  task automatic drive_operands(input int a, input int b, input int n);
    i_a       = a[W-1:0];
    i_b       = b[W-1:0];
    i_modulus = n[W-1:0];
  endtask

  // Full transaction: accept, wait for o_valid, retire. Leaves time at posedge+1.
  task automatic run_op(input int a, input int b, input int n,
                        output int result, output int latency, output bit ok);
    bit acc;
    ok = 1'b0;
    latency = 0;
    result = -1;
    acc = 1'b0;
    drive_operands(a, b, n);
    i_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = i_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (acc) begin
      while (!o_valid && latency < 100) begin
        @(posedge clk); #1;
        latency++;
      end
      ok = o_valid;
      result = int'(o_out);
      o_ready = 1'b1;
      @(posedge clk); #1;
      o_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_i_ready got %b want 1", i_ready); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid got %b want 0", o_valid); end
    checks++;
    if (o_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_o_out got %0d want 0", o_out); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int res, lat;
    bit ok;
    run_op(5, 7, 13, res, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL basic_timeout got no o_valid want o_valid"); end
    checks++;
    if (res != 1) begin errors++; $display("[TB] FAIL basic_result got %0d want 1", res); end
    checks++;
    if (lat != 9) begin errors++; $display("[TB] FAIL basic_latency got %0d want 9", lat); end
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after got %b want 1", i_ready); end
  endtask

  task automatic test_inverse();
    int res, lat;
    bit ok;
    run_op(1, 1, 13, res, lat, ok);
    checks++;
    if (!ok || res != 3) begin errors++; $display("[TB] FAIL inverse_r got %0d want 3", res); end
    run_op(0, 1, 13, res, lat, ok);
    checks++;
    if (!ok || res != 0) begin errors++; $display("[TB] FAIL zero_a got %0d want 0", res); end
  endtask

  task automatic test_max();
    int res, lat;
    bit ok;
    run_op(254, 254, 255, res, lat, ok);
    checks++;
    if (!ok || res != 1) begin errors++; $display("[TB] FAIL max_operands got %0d want 1", res); end
    checks++;
    if (lat != 9) begin errors++; $display("[TB] FAIL max_latency got %0d want 9", lat); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int waited;
    int bad_valid, bad_out, bad_ready, bad_idle;
    logic [W-1:0] held;
    acc = 1'b0;
    waited = 0;
    bad_valid = 0; bad_out = 0; bad_ready = 0; bad_idle = 0;
    o_ready = 1'b0;
    drive_operands(5, 7, 13);
    i_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = i_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    while (!o_valid && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!o_valid) begin errors++; $display("[TB] FAIL bp_timeout got no o_valid want o_valid"); end
    held = o_out;
    checks++;
    if (held !== 8'd1) begin errors++; $display("[TB] FAIL bp_result got %0d want 1", held); end
    drive_operands(3, 4, 11);
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b1) bad_valid++;
      if (o_out !== held) bad_out++;
      if (i_ready !== 1'b0) bad_ready++;
    end
    checks++;
    if (bad_valid != 0) begin errors++; $display("[TB] FAIL bp_valid_held got %0d drops want 0", bad_valid); end
    checks++;
    if (bad_out != 0) begin errors++; $display("[TB] FAIL bp_out_stable got %0d changes want 0", bad_out); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("[TB] FAIL bp_ready_low got %0d highs want 0", bad_ready); end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_retire_valid got %b want 0", o_valid); end
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_retire_ready got %b want 1", i_ready); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0 || i_ready !== 1'b1) bad_idle++;
    end
    checks++;
    if (bad_idle != 0) begin errors++; $display("[TB] FAIL bp_no_second_accept got %0d busy cycles want 0", bad_idle); end
  endtask

  task automatic test_back_to_back();
    int ta[100];
    int tb_[100];
    int tn[100];
    int expv[100];
    int results, dups, waited;
    bit acc;
    results = 0;
    dups = 0;
    for (int k = 0; k < 100; k++) begin
      tn[k]  = 2 * int'($urandom_range(1, 127)) + 1;
      ta[k]  = int'($urandom_range(0, tn[k] - 1));
      tb_[k] = int'($urandom_range(0, tn[k] - 1));
      expv[k] = mont_ref(ta[k], tb_[k], tn[k]);
    end
    o_ready = 1'b1;
    i_valid = 1'b1;
    drive_operands(ta[0], tb_[0], tn[0]);
    for (int k = 0; k < 100; k++) begin
      acc = 1'b0;
      for (int j = 0; j < 20 && !acc; j++) begin
        acc = i_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("[TB] FAIL b2b_accept_timeout got no accept want accept at item %0d", k);
        break;
      end
      if (k < 99) drive_operands(ta[k+1], tb_[k+1], tn[k+1]);
      waited = 0;
      while (!o_valid && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!o_valid) begin
        checks++; errors++;
        $display("[TB] FAIL b2b_valid_timeout got no o_valid want o_valid at item %0d", k);
        break;
      end
      results++;
      checks++;
      if (int'(o_out) != expv[k]) begin
        errors++;
        $display("[TB] FAIL b2b_item%0d got %0d want %0d (a=%0d b=%0d n=%0d)",
                 k, o_out, expv[k], ta[k], tb_[k], tn[k]);
      end
      @(posedge clk); #1;
      if (o_valid) dups++;
    end
    i_valid = 1'b0;
    o_ready = 1'b0;
    checks++;
    if (results != 100) begin errors++; $display("[TB] FAIL b2b_count got %0d want 100", results); end
    checks++;
    if (dups != 0) begin errors++; $display("[TB] FAIL b2b_duplicates got %0d want 0", dups); end
  endtask

  task automatic test_mid_reset();
    bit acc, ok;
    int res, lat, stray;
    acc = 1'b0;
    stray = 0;
    drive_operands(200, 100, 251);
    i_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = i_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", o_valid); end
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", i_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("[TB] FAIL midrst_stray_valid got %0d want 0", stray); end
    run_op(5, 7, 13, res, lat, ok);
    checks++;
    if (!ok || res != 1) begin errors++; $display("[TB] FAIL midrst_result got %0d want 1", res); end
    checks++;
    if (lat != 9) begin errors++; $display("[TB] FAIL midrst_latency got %0d want 9", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/montgomery_mul.md
# montgomery_mul

Bit-serial Montgomery multiplier for the RSA datapath: computes `o_out = a * b * 2^(-MOD_WIDTH) mod modulus`, processing one bit of `a` per clock. It sits directly downstream of the two-power precompute stage. That stage supplies `2^(2*MOD_WIDTH) mod N`, which enters here as operand `b` to convert values into the Montgomery domain. The block is also reused by the exponentiation loop for squaring and multiplication. Input and output use the standard valid/ready handshake so the block chains with the neighbouring pipeline stages.

## Interface
- `MOD_WIDTH`, default 256 — operand and modulus width in bits; also the number of iterations.
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-low reset.
- `i_valid`  input  1  — input operands valid.
- `i_ready`  output  1  — block can accept operands.
- `i_a`  input  MOD_WIDTH  — multiplier operand; its bits are scanned LSB first.
- `i_b`  input  MOD_WIDTH  — multiplicand operand.
- `i_modulus`  input  MOD_WIDTH  — modulus N.
- `o_valid`  output  1  — result valid.
- `o_ready`  input  1  — downstream accepts the result.
- `o_out`  output  MOD_WIDTH  — Montgomery product.

## Operation
- Preconditions, not checked by the block:
  - N is odd.
  - N > 1.
  - a < N and b < N.
- States: IDLE, LOOP, FINAL, OUT.
- IDLE:
  - `i_ready = 1`.
  - On `i_valid && i_ready`, latch a, b and N, clear the accumulator r and the counter, then go to LOOP.
- LOOP, one iteration per cycle, with i = counter:
  - `s = r + (a[i] ? b : 0)`
  - `s = s + (s[0] ? N : 0)`
  - `r = s >> 1`
  - counter increments each iteration.
  - After iteration MOD_WIDTH-1, go to FINAL.
- FINAL:
  - `r = (r >= N) ? r - N : r`. The comparison is `>=`, so r == N yields 0.
  - Then go to OUT.
- OUT:
  - `o_valid = 1`, and `o_out` = r[MOD_WIDTH-1:0].
  - On `o_valid && o_ready`, go to IDLE.
- Width rules:
  - The invariant r < 2N holds throughout.
  - r is held in MOD_WIDTH+1 bits.
  - The intermediate sum s needs MOD_WIDTH+2 bits and must not be truncated.
  - Counter width is clog2(MOD_WIDTH)+1.
- Latched operands hold from acceptance until the next acceptance. Input pins are ignored outside the IDLE handshake.

## Timing
- Reset (asynchronous, `rst` low):
  - State goes to IDLE.
  - `o_valid = 0`, `o_out = 0`, `i_ready = 1` immediately.
  - Counter, r and the latched operands clear to 0.
- Reset asserted mid-LOOP, FINAL or OUT:
  - The operation is aborted.
  - No `o_valid` pulse is produced for it.
- Latency:
  - Let E0 be the edge on which the input is accepted.
  - The LOOP iterations occur on edges E0+1 … E0+MOD_WIDTH.
  - FINAL occurs on edge E0+MOD_WIDTH+1.
  - `o_valid` is high from that edge onward.
  - Latency is MOD_WIDTH+1 cycles from acceptance to `o_valid`.
- `i_ready` is combinational from state (IDLE only). It is low during LOOP, FINAL and OUT.
- One transaction is in flight at a time. There is no acceptance in the same cycle as output retirement: after the output handshake edge, `i_ready` rises in the following cycle.
- Backpressure: while OUT is held with `o_ready` = 0:
  - `o_valid` stays high.
  - `o_out` is stable.
  - `i_ready` stays low.
- If `o_ready` is already 1 when `o_valid` rises, the output retires on the first OUT edge.
- No combinational path from `i_valid` to `o_valid`, or from `o_ready` to `i_ready`.

## Test plan
All scenarios use MOD_WIDTH = 8, so R = 256.
- Basic product: N=13, a=5, b=7 → `o_out` = 1, with `o_valid` rising exactly 9 cycles after the accept edge.
- Inverse of R: N=13, a=1, b=1 → `o_out` = 3 (256⁻¹ mod 13). Same inputs with a=0 → `o_out` = 0.
- Maximum operands: N=255, a=254, b=254 → `o_out` = 1. This exercises the s carry into bit MOD_WIDTH+1 and the final subtraction.
- Backpressure: hold `o_ready`=0 for 20 cycles after `o_valid` rises → `o_out` is stable, `i_ready`=0 and a second `i_valid` is not accepted. Raise `o_ready` → one handshake, then `i_ready`=1 on the next cycle.
- Back-to-back: keep `i_valid` and `o_ready` high and stream 100 random (a, b < N, odd N) tuples → each result equals the reference model `a*b*inv(256) mod N`, in order, with exactly one result per accept.
- Mid-operation reset: assert `rst` low 4 cycles after an accept → `o_valid`=0 and `i_ready`=1 immediately. A new operation after release (N=13, a=5, b=7) returns 1 with nominal latency.
